cgra0_out_packer: RTL

- Downstream consumer of the PE output stage's fifo_data/fifo_we stream.
- Packs 16-bit result words into 128-bit lines and buffers them in a small line FIFO.
- Presents lines to the accelerator memory writer over a valid/ready handshake, flagged with a word-valid strobe and an end-of-stream marker.
- Raises almost_full so the control unit can drop the CGRA en before any overflow.

---
 rtl/cgra0_pkg.sv | 11 +
 rtl/cgra0_line_fifo.sv | 60 ++++++
 rtl/cgra0_out_packer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cgra0_pkg.sv
// Accelerator-level constants for the cgra0 output path.
package cgra0_pkg;

  localparam int unsigned CGRA0_DATA_WIDTH = 16;
  localparam int unsigned CGRA0_OUT_WIDTH  = 128;
  localparam int unsigned CGRA0_LINE_DEPTH = 4;
  localparam int unsigned CGRA0_AF_MARGIN  = 1;
  localparam int unsigned WORDS_PER_LINE   = CGRA0_OUT_WIDTH / CGRA0_DATA_WIDTH;
  localparam int unsigned PIDX_W           = $clog2(WORDS_PER_LINE);

endpackage

// File: rtl/cgra0_line_fifo.sv
// First-word fall-through line FIFO; a push and a pop in the same cycle
// are both accepted even when full.
module cgra0_line_fifo #(
  parameter  int unsigned WIDTH = 137,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    wptr_d  = wptr_q + PTR_W'(wr_en);
    rptr_d  = rptr_q + PTR_W'(rd_en);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // Head is forced to zero when empty so stale lines never show on the outputs.
  assign rd_data = empty ? '0 : mem_q[rptr_q];
  assign count   = count_q;

endmodule

// File: rtl/cgra0_out_packer.sv
// Packs PE result words into output lines, queues them and presents them
// to the memory writer with strobe, end-of-stream and status flags.
module cgra0_out_packer
  import cgra0_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = CGRA0_DATA_WIDTH,
  parameter  int unsigned OUT_WIDTH  = CGRA0_OUT_WIDTH,
  parameter  int unsigned DEPTH      = CGRA0_LINE_DEPTH,
  parameter  int unsigned AF_MARGIN  = CGRA0_AF_MARGIN,
  localparam int unsigned W          = OUT_WIDTH / DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  fifo_we,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [W-1:0]          out_strb,
  output logic                  out_last,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned PW    = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = OUT_WIDTH + W + 1;

  logic [OUT_WIDTH-1:0] line_q, line_d, cur_line;
  logic [W-1:0]         strb_q, strb_d, cur_strb;
  logic [PW-1:0]        pidx_q, pidx_d;
  logic                 flush_pending_q, flush_pending_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;
  logic                 af_q, af_d;
  logic                 word_ok, line_done, flush_act;
  logic                 push_req, push_acc, pop, can_push;
  logic [CNT_W-1:0]     count, count_d;
  logic                 full, empty;
  logic [ENT_W-1:0]     head;

  assign pop       = ~empty & out_ready;
  assign can_push  = ~full | pop;
  assign flush_act = flush | flush_pending_q;
  assign word_ok   = fifo_we & ~flush_pending_q;
  assign line_done = word_ok & (pidx_q == PW'(W - 1));
  assign push_req  = line_done | flush_act;
  assign push_acc  = push_req & can_push;

  always_comb begin
    cur_line = line_q;
    cur_strb = strb_q;
    if (word_ok) begin
      cur_line[pidx_q*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      cur_strb[pidx_q] = 1'b1;
    end
  end

  always_comb begin
    line_d = cur_line;
    strb_d = cur_strb;
    pidx_d = pidx_q;
    if (word_ok) begin
      pidx_d = (pidx_q == PW'(W - 1)) ? '0 : pidx_q + 1'b1;
    end
    flush_pending_d = flush_act & ~can_push;
    // A blocked full line is dropped, but a blocked flush keeps its line for the retry.
    if (push_acc || (line_done && !flush_act)) begin
      line_d = '0;
      strb_d = '0;
      pidx_d = '0;
    end
    overflow_d = overflow_q
               | (line_done & ~flush_act & ~can_push)
               | (fifo_we & flush_pending_q);
    done_d = done_q | (pop & head[ENT_W-1]);
    if (start) begin
      overflow_d = 1'b0;
      done_d     = 1'b0;
    end
    count_d = count + CNT_W'(push_acc) - CNT_W'(pop);
    af_d    = (CNT_W'(DEPTH) - count_d) <= CNT_W'(AF_MARGIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q          <= '0;
      strb_q          <= '0;
      pidx_q          <= '0;
      flush_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      done_q          <= 1'b0;
      af_q            <= 1'b0;
    end else begin
      line_q          <= line_d;
      strb_q          <= strb_d;
      pidx_q          <= pidx_d;
      flush_pending_q <= flush_pending_d;
      overflow_q      <= overflow_d;
      done_q          <= done_d;
      af_q            <= af_d;
    end
  end

  cgra0_line_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_line_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_acc),
    .wr_data ({flush_act, cur_strb, cur_line}),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid                       = ~empty;
  assign {out_last, out_strb, out_data}  = head;
  assign almost_full                     = af_q;
  assign overflow                        = overflow_q;
  assign done                            = done_q;

endmodule
